// File: rtl/pipeline_credit_fifo_if.sv
// rtl/pipeline_credit_fifo_if.sv - handshake bundle for the credit-managed output FIFO
//
// Groups the credit, pipeline-capture and consumer stream signals.
//   slave  : the FIFO side (pipeline_credit_fifo)
//   master : the producer/consumer side (pipeline model and sink)
// Signals:
//   issue_valid_in / issue_ready_out : producer credit handshake
//   pipe_valid_in / pipe_data_in     : item emerging from the fixed-latency pipeline
//   data_out / valid_out / ready_in  : show-ahead output stream
//   count_out                        : FIFO occupancy
//   overflow_out                     : sticky write-while-full error
interface pipeline_credit_fifo_if #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic                  issue_valid_in;
    logic                  issue_ready_out;
    logic                  pipe_valid_in;
    logic [DATA_WIDTH-1:0] pipe_data_in;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  valid_out;
    logic                  ready_in;
    logic [CW-1:0]         count_out;
    logic                  overflow_out;

    modport slave (
        input  issue_valid_in, pipe_valid_in, pipe_data_in, ready_in,
        output issue_ready_out, data_out, valid_out, count_out, overflow_out
    );

    modport master (
        output issue_valid_in, pipe_valid_in, pipe_data_in, ready_in,
        input  issue_ready_out, data_out, valid_out, count_out, overflow_out
    );
endinterface

// File: rtl/pipeline_credit_fifo.sv
// rtl/pipeline_credit_fifo.sv - credit-managed show-ahead FIFO behind a non-stallable pipeline
//
// Ports:
//   clk_in  : clock, rising edge
//   rst_in  : synchronous active-high reset
//   bus     : pipeline_credit_fifo_if.slave
//             credits are handed out on issue_valid_in/issue_ready_out, returned
//             on every consumer pop; items arriving on pipe_valid_in are stored
//             and presented on data_out/valid_out/ready_in.
module pipeline_credit_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    pipeline_credit_fifo_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [CW-1:0]         credits_q, credits_d;
    logic [CW-1:0]         count_q, count_d;
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic                  overflow_q, overflow_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic issue;
    logic pop;
    logic full;
    logic wr_en;

    always_comb begin
        issue = bus.issue_valid_in && (credits_q != '0);
        pop   = bus.ready_in && (count_q != '0);
        full  = (count_q == DEPTH_C);
        // A write into a full FIFO is only safe when the head leaves the same cycle.
        wr_en = bus.pipe_valid_in && (!full || pop);

        credits_d = credits_q;
        if (issue && !pop) begin
            credits_d = credits_q - CW'(1);
        end else if (pop && !issue) begin
            credits_d = credits_q + CW'(1);
        end

        count_d = count_q;
        if (wr_en && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !wr_en) begin
            count_d = count_q - CW'(1);
        end

        wr_ptr_d = wr_ptr_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end

        rd_ptr_d = rd_ptr_q;
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end

        overflow_d = overflow_q || (bus.pipe_valid_in && full && !pop);
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            credits_q  <= DEPTH_C;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            credits_q  <= credits_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage carries no reset; contents are only observable while count is non-zero.
    always_ff @(posedge clk_in) begin
        if (!rst_in && wr_en) begin
            mem_q[wr_ptr_q] <= bus.pipe_data_in;
        end
    end

    assign bus.issue_ready_out = (credits_q != '0);
    assign bus.data_out        = mem_q[rd_ptr_q];
    assign bus.valid_out       = (count_q != '0);
    assign bus.count_out       = count_q;
    assign bus.overflow_out    = overflow_q;
endmodule

// File: tb/tb_pipeline_credit_fifo.sv
// tb/tb_pipeline_credit_fifo.sv - scoreboard bench for pipeline_credit_fifo with a 3-stage pipeline model
module tb_pipeline_credit_fifo;
    logic clk = 1'b0;
    logic rst_in = 1'b0;

    always #5 clk = ~clk;

    pipeline_credit_fifo_if #(.DATA_WIDTH(32), .DEPTH(8)) bus ();

    pipeline_credit_fifo #(.DATA_WIDTH(32), .DEPTH(8)) dut (
        .clk_in (clk),
        .rst_in (rst_in),
        .bus    (bus)
    );

    int total = 0;
    int bad = 0;
    int pop_cnt = 0;
    logic [31:0] q [$];

    // Latency-3 pipeline model: stage registers advanced once per cycle by the driver.
    logic        pv0 = 1'b0, pv1 = 1'b0, pv2 = 1'b0;
    logic [31:0] pd0 = '0, pd1 = '0, pd2 = '0;
    logic        fire_prev = 1'b0;
    logic [31:0] d_prev = '0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    task automatic cyc(input logic iv, input logic [31:0] id, input logic rdy,
                       input logic fv = 1'b0, input logic [31:0] fd = 32'h0,
                       input logic fpush = 1'b0);
        @(negedge clk);
        pv2 = pv1; pd2 = pd1;
        pv1 = pv0; pd1 = pd0;
        pv0 = fire_prev; pd0 = d_prev;
        bus.pipe_valid_in  = pv2 | fv;
        bus.pipe_data_in   = fv ? fd : pd2;
        if (fv && fpush) q.push_back(fd);
        bus.issue_valid_in = iv;
        bus.ready_in       = rdy;
        #1;
        fire_prev = iv && (bus.issue_ready_out === 1'b1);
        d_prev    = id;
        if (fire_prev) q.push_back(id);
    endtask

    task automatic idle(input logic rdy, input int n);
        repeat (n) cyc(1'b0, 32'h0, rdy);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_in = 1'b1;
        bus.issue_valid_in = 1'b0;
        bus.pipe_valid_in  = 1'b0;
        bus.pipe_data_in   = '0;
        bus.ready_in       = 1'b0;
        pv0 = 1'b0; pv1 = 1'b0; pv2 = 1'b0;
        fire_prev = 1'b0;
        q.delete();
        @(negedge clk);
        @(negedge clk);
        rst_in = 1'b0;
        #1;
    endtask

    // Monitor: every accepted output beat is compared with the oldest issued item.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!rst_in && bus.valid_out === 1'b1 && bus.ready_in === 1'b1) begin
                pop_cnt++;
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL out_unexpected: got %h expected no item", bus.data_out);
                end else begin
                    chk("out_data", bus.data_out, q.pop_front());
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int start;
        bus.issue_valid_in = 1'b0;
        bus.pipe_valid_in  = 1'b0;
        bus.pipe_data_in   = '0;
        bus.ready_in       = 1'b0;

        // Reset
        do_reset();
        chk("rst_valid", 32'(bus.valid_out), 32'd0);
        chk("rst_issue_ready", 32'(bus.issue_ready_out), 32'd1);
        chk("rst_count", 32'(bus.count_out), 32'd0);
        chk("rst_overflow", 32'(bus.overflow_out), 32'd0);

        // Single item: visible 4 cycles after issue, popped immediately
        cyc(1'b1, 32'hDEADBEEF, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 32'h0, 1'b1);
            chk("single_not_yet", 32'(bus.valid_out), 32'd0);
        end
        cyc(1'b0, 32'h0, 1'b1);
        chk("single_valid", 32'(bus.valid_out), 32'd1);
        chk("single_count", 32'(bus.count_out), 32'd1);
        cyc(1'b0, 32'h0, 1'b1);
        chk("single_empty", 32'(bus.valid_out), 32'd0);
        chk("single_count0", 32'(bus.count_out), 32'd0);

        // Credit exhaustion: 8 credits, 9th attempt ignored
        for (int i = 0; i < 9; i++) begin
            cyc(1'b1, 32'(i + 1), 1'b0);
            chk("exh_issue_ready", 32'(bus.issue_ready_out), (i < 8) ? 32'd1 : 32'd0);
        end
        idle(1'b0, 4);
        chk("exh_count", 32'(bus.count_out), 32'd8);
        chk("exh_issue_ready_full", 32'(bus.issue_ready_out), 32'd0);
        chk("exh_overflow", 32'(bus.overflow_out), 32'd0);

        // Drain order and pointer wrap
        cyc(1'b0, 32'h0, 1'b1);
        chk("pop1_ready_before", 32'(bus.issue_ready_out), 32'd0);
        cyc(1'b0, 32'h0, 1'b1);
        chk("pop1_ready_after", 32'(bus.issue_ready_out), 32'd1);
        cyc(1'b0, 32'h0, 1'b1);
        cyc(1'b1, 32'd9, 1'b0);
        chk("wrap_count5", 32'(bus.count_out), 32'd5);
        chk("wrap_ready3", 32'(bus.issue_ready_out), 32'd1);
        cyc(1'b1, 32'd10, 1'b0);
        cyc(1'b1, 32'd11, 1'b0);
        cyc(1'b0, 32'h0, 1'b1);
        chk("wrap_credits0", 32'(bus.issue_ready_out), 32'd0);
        idle(1'b1, 12);
        chk("wrap_count_end", 32'(bus.count_out), 32'd0);
        chk("wrap_queue_empty", 32'(q.size()), 32'd0);

        // Steady state: issue and pop every cycle
        start = pop_cnt;
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1, 32'h1000 + 32'(i), 1'b1);
            if (i >= 4) begin
                chk("steady_count", 32'(bus.count_out), 32'd1);
                chk("steady_ready", 32'(bus.issue_ready_out), 32'd1);
            end
        end
        #2;
        chk("steady_throughput", 32'(pop_cnt - start), 32'd16);
        idle(1'b1, 6);
        chk("steady_drain_count", 32'(bus.count_out), 32'd0);
        chk("steady_queue_empty", 32'(q.size()), 32'd0);

        // Full FIFO: write with simultaneous pop accepted, write without pop dropped
        for (int i = 0; i < 8; i++) cyc(1'b1, 32'h200 + 32'(i), 1'b0);
        idle(1'b0, 4);
        chk("viol_full", 32'(bus.count_out), 32'd8);
        cyc(1'b0, 32'h0, 1'b1, 1'b1, 32'h77, 1'b1);
        cyc(1'b0, 32'h0, 1'b0, 1'b1, 32'h55, 1'b0);
        chk("full_pop_write_count", 32'(bus.count_out), 32'd8);
        chk("full_pop_write_ovf", 32'(bus.overflow_out), 32'd0);
        cyc(1'b0, 32'h0, 1'b0);
        chk("viol_count", 32'(bus.count_out), 32'd8);
        chk("viol_overflow", 32'(bus.overflow_out), 32'd1);
        idle(1'b0, 2);
        chk("viol_sticky", 32'(bus.overflow_out), 32'd1);
        idle(1'b1, 10);
        chk("viol_drain_count", 32'(bus.count_out), 32'd0);
        chk("viol_sticky_drain", 32'(bus.overflow_out), 32'd1);
        chk("viol_queue_empty", 32'(q.size()), 32'd0);

        // Reset clears the sticky error
        do_reset();
        chk("rst2_overflow", 32'(bus.overflow_out), 32'd0);
        chk("rst2_count", 32'(bus.count_out), 32'd0);
        chk("rst2_valid", 32'(bus.valid_out), 32'd0);
        chk("rst2_issue_ready", 32'(bus.issue_ready_out), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
